adam_aes_key_expansion_multi: RTL and testbench
===============================================

// Module: adam_aes_key_expansion_multi
//
// PURPOSE
// Iterative AES key expansion supporting AES-128/192/256, selected per init.
// Generates one 32-bit schedule word per cycle into an internal word store.
// Exposes round keys through an indexed read port, not a flat output array.
// Sits between the AES peripheral register file and the cipher datapath.
//
// PARAMETERS
// MAX_NK     8   largest supported key length in 32-bit words (4, 6 or 8)
// MAX_NR     derived = MAX_NK+6; largest round count
// MAX_WORDS  derived = 4*(MAX_NR+1); word store depth (60 for MAX_NK=8)
//
// PORTS
// clk         in   1    clock
// reset_n     in   1    synchronous reset, active low
// init        in   1    start expansion of key/keylen (sampled when not busy)
// keylen      in   2    00=128, 01=192, 10=256, 11=illegal
// key         in   256  key, MSB-aligned: word0=key[255:224]; unused LSBs ignored
// ready       out  1    schedule complete; held high until next accepted init
// busy        out  1    expansion in progress
// keylen_err  out  1    last init had illegal/unsupported keylen; sticky
// num_rounds  out  4    Nr of current schedule (10/12/14); 0 after reset
// rk_idx      in   4    round key index to read
// rk_data     out  128  {w[4i],w[4i+1],w[4i+2],w[4i+3]}, registered
//
// BEHAVIOUR
// - Reset (reset_n=0 at a clk edge) forces the state listed below.
//   It applies even mid-expansion: partial schedule discarded, no ready.
//   - state IDLE; ready=0, busy=0, keylen_err=0, num_rounds=0, rk_data=0.
//   - Word store and counters cleared to 0.
// - Nk=4/6/8 and Nr=10/12/14 from keylen; Nw=4*(Nr+1)=44/52/60.
// - keylen=11, or Nk>MAX_NK: keylen_err=1, ready=0, stay IDLE, store untouched.
// - FSM states and transitions:
//   - IDLE: init with legal keylen -> EXPAND.
//     - Write w[0..Nk-1] from key; latch Nk and Nr.
//     - Set i=Nk; clear ready and keylen_err.
//   - EXPAND: one word per cycle, i increments.
//     - Leave to DONE after writing w[Nw-1].
//   - DONE: ready=1, busy=0, num_rounds=Nr.
//     - init restarts exactly as from IDLE; ready drops the next cycle.
// - busy=1 exactly while in EXPAND. init during EXPAND is ignored.
// - Word rule for each index i:
//   - t=w[i-1].
//   - If i%Nk==0: t=SubWord(RotWord(t))^{Rcon[i/Nk],24'h0}.
//   - Else if Nk==8 and i%8==4: t=SubWord(t).
//   - w[i]=w[i-Nk]^t.
// - RotWord(a,b,c,d)=(b,c,d,a). Rcon[1..10]=01,02,04,08,10,20,40,80,1B,36.
// - Modulo and i/Nk are tracked by a wrapping j counter (0..Nk-1) plus an
//   rcon index. No dividers. Four shared S-box instances.
// - Latency: init accepted at cycle T.
//   - Expansion takes Nw-Nk cycles, so ready=1 at T+41 / T+47 / T+53.
// - Read port has 1-cycle latency: rk_data(t+1)=f(rk_idx(t)).
//   - rk_idx>num_rounds returns 0.
//   - Reads during EXPAND return current store contents; not checked.
// - Store writes and read-port sampling in the same cycle: read returns the
//   pre-write value.
//
// TESTING
// - FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, keylen=00
//   -> ready at T+41; num_rounds=10; rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
// - FIPS-197 A.2 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, keylen=01
//   -> ready at T+47; rk_idx=12 gives e98ba06f448c773c8ecc720401002202.
// - FIPS-197 A.3 key 603deb10...0914dff4, keylen=10
//   -> ready at T+53; rk_idx=14 gives fe4890d1e6188d0b046df344706c631e; rk_idx=15 gives 0.
// - keylen=11 with init -> keylen_err=1 next cycle, ready=0, busy=0.
//   Then a legal init clears keylen_err.
// - Pulse reset_n=0 at T+20 of a 256-bit run -> next cycle all outputs 0 and state IDLE.
//   A subsequent 128-bit init completes correctly.
// - Back-to-back: init again while ready=1 (DONE), 128 then 256
//   -> ready low at T+1, busy T+1..T+52, new rk_data matches A.3.

Source files
------------

// File: rtl/adam_aes_key_expansion_multi.sv
// Iterative AES-128/192/256 key expansion: one schedule word per cycle into an
// internal word store, round keys read back through a registered indexed port.

module adam_aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   localparam logic [0:255][7:0] SBOX = {
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign y = SBOX[a];
endmodule

module adam_aes_key_expansion_multi #(
   parameter int MAX_NK = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         init,
   input  logic [1:0]   keylen,
   input  logic [255:0] key,
   output logic         ready,
   output logic         busy,
   output logic         keylen_err,
   output logic [3:0]   num_rounds,
   input  logic [3:0]   rk_idx,
   output logic [127:0] rk_data
);
   localparam int MAX_NR    = MAX_NK + 6;
   localparam int MAX_WORDS = 4 * (MAX_NR + 1);

   typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

   state_t            state;
   logic [31:0]       w [MAX_WORDS];
   logic [5:0]        i;
   logic [5:0]        nw_last;
   logic [2:0]        j;
   logic [2:0]        j_last;
   logic [3:0]        nk;
   logic [3:0]        nr;
   logic [3:0]        rcon_idx;

   logic [3:0]        nk_sel;
   logic [3:0]        nr_sel;
   logic              keylen_bad;
   logic [0:7][31:0]  key_w;
   logic [31:0]       prev_w, back_w, rot_w, sub_in, sub_out, t_w, new_w;
   logic [5:0]        rk_base;

   function automatic logic [7:0] rcon(input logic [3:0] n);
      case (n)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

   assign key_w   = key;
   assign rk_base = {rk_idx, 2'b00};

   always_comb begin
      case (keylen)
         2'b00:   nk_sel = 4'd4;
         2'b01:   nk_sel = 4'd6;
         2'b10:   nk_sel = 4'd8;
         default: nk_sel = 4'd0;
      endcase
      nr_sel     = nk_sel + 4'd6;
      keylen_bad = (keylen == 2'b11) || (int'(nk_sel) > MAX_NK);
   end

   // j tracks i mod Nk; rcon_idx tracks i/Nk, so no divider is needed
   assign prev_w = w[i - 6'd1];
   assign back_w = w[i - {2'b00, nk}];
   assign rot_w  = {prev_w[23:0], prev_w[31:24]};
   assign sub_in = (j == 3'd0) ? rot_w : prev_w;

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      adam_aes_sbox u_sbox (.a(sub_in[8*b +: 8]), .y(sub_out[8*b +: 8]));
   end

   always_comb begin
      if (j == 3'd0)
         t_w = sub_out ^ {rcon(rcon_idx), 24'h0};
      else if (nk == 4'd8 && j == 3'd4)
         t_w = sub_out;
      else
         t_w = prev_w;
      new_w = back_w ^ t_w;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         ready      <= 1'b0;
         busy       <= 1'b0;
         keylen_err <= 1'b0;
         num_rounds <= '0;
         rk_data    <= '0;
         i          <= '0;
         nw_last    <= '0;
         j          <= '0;
         j_last     <= '0;
         nk         <= '0;
         nr         <= '0;
         rcon_idx   <= '0;
         for (int unsigned k = 0; k < MAX_WORDS; k++)
            w[k[5:0]] <= '0;
      end else begin
         rk_data <= (rk_idx > num_rounds) ? '0 :
                    {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
         case (state)
            S_IDLE, S_DONE: begin
               if (init) begin
                  ready <= 1'b0;
                  if (keylen_bad) begin
                     keylen_err <= 1'b1;
                     state      <= S_IDLE;
                  end else begin
                     for (int unsigned k = 0; k < MAX_NK; k++)
                        if (k < {28'd0, nk_sel})
                           w[k[5:0]] <= key_w[k[2:0]];
                     nk         <= nk_sel;
                     nr         <= nr_sel;
                     nw_last    <= {nr_sel + 4'd1, 2'b00} - 6'd1;
                     i          <= {2'b00, nk_sel};
                     j          <= '0;
                     j_last     <= 3'(nk_sel - 4'd1);
                     rcon_idx   <= 4'd1;
                     keylen_err <= 1'b0;
                     busy       <= 1'b1;
                     state      <= S_EXPAND;
                  end
               end
            end
            S_EXPAND: begin
               w[i] <= new_w;
               i    <= i + 6'd1;
               if (j == j_last) begin
                  j        <= '0;
                  rcon_idx <= rcon_idx + 4'd1;
               end else begin
                  j <= j + 3'd1;
               end
               if (i == nw_last) begin
                  busy       <= 1'b0;
                  ready      <= 1'b1;
                  num_rounds <= nr;
                  state      <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_adam_aes_key_expansion_multi.sv
// Scoreboard bench for adam_aes_key_expansion_multi using FIPS-197 key expansion vectors.

module tb_adam_aes_key_expansion_multi;
   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         init = 1'b0;
   logic [1:0]   keylen = 2'b00;
   logic [255:0] key = '0;
   logic         ready, busy, keylen_err;
   logic [3:0]   num_rounds;
   logic [3:0]   rk_idx = 4'd15;
   logic [127:0] rk_data;

   adam_aes_key_expansion_multi #(.MAX_NK(8)) dut (
      .clk(clk), .reset_n(reset_n), .init(init), .keylen(keylen), .key(key),
      .ready(ready), .busy(busy), .keylen_err(keylen_err), .num_rounds(num_rounds),
      .rk_idx(rk_idx), .rk_data(rk_data)
   );

   always #5 clk = ~clk;

   localparam logic [255:0] KEY_A1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] KEY_A2 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int t_init   = 0;

   string        q_st_name[$];
   logic [135:0] q_st_exp[$];
   string        q_rd_name[$];
   logic [135:0] q_rd_exp[$];
   string        q_lat_name[$];
   logic [135:0] q_lat_exp[$];

   logic st_req  = 1'b0;
   logic rd_req  = 1'b0;
   logic rd_fire = 1'b0;
   logic ready_prev = 1'b0;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rd_fire <= rd_req;
   end

   task automatic check(input string nm, input logic [135:0] act, input logic [135:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Monitor: pops one expectation per observed DUT event
   always @(negedge clk) begin
      if (st_req) begin
         if (q_st_exp.size() == 0) begin
            n_checks++;
            $display("FAIL status_unexpected: got status sample expected none queued");
         end else
            check(q_st_name.pop_front(),
                  {1'b0, ready, busy, keylen_err, num_rounds, rk_data}, q_st_exp.pop_front());
      end
      if (rd_fire) begin
         if (q_rd_exp.size() == 0) begin
            n_checks++;
            $display("FAIL read_unexpected: got %h expected none queued", rk_data);
         end else
            check(q_rd_name.pop_front(), {8'h0, rk_data}, q_rd_exp.pop_front());
      end
      if (ready && !ready_prev) begin
         if (q_lat_exp.size() == 0) begin
            n_checks++;
            $display("FAIL ready_unexpected: got ready=1 at cycle %0d expected ready=0", cyc);
         end else
            check(q_lat_name.pop_front(),
                  {123'h0, 8'(cyc - t_init), num_rounds, busy}, q_lat_exp.pop_front());
      end
      ready_prev <= ready;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic st_check(input string nm, input logic r, input logic b, input logic e,
                           input logic [3:0] nr);
      q_st_name.push_back(nm);
      q_st_exp.push_back({1'b0, r, b, e, nr, 128'h0});
      st_req = 1'b1;
      @(negedge clk);
      #1;
      st_req = 1'b0;
   endtask

   task automatic rd_check(input string nm, input logic [3:0] idx, input logic [127:0] exp);
      q_rd_name.push_back(nm);
      q_rd_exp.push_back({8'h0, exp});
      rk_idx = idx;
      rd_req = 1'b1;
      tick();
      rk_idx = 4'd15;
      rd_req = 1'b0;
   endtask

   task automatic start(input logic [1:0] kl, input logic [255:0] k);
      init   = 1'b1;
      keylen = kl;
      key    = k;
      t_init = cyc;
      tick();
      init = 1'b0;
   endtask

   task automatic expect_ready(input string nm, input logic [7:0] lat, input logic [3:0] nr);
      q_lat_name.push_back(nm);
      q_lat_exp.push_back({123'h0, lat, nr, 1'b0});
   endtask

   task automatic wait_ready();
      for (int c = 0; c < 200 && !ready; c++) tick();
      tick();
   endtask

   initial begin
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      st_check("reset_state", 1'b0, 1'b0, 1'b0, 4'd0);

      tick();
      start(2'b11, KEY_A1);
      st_check("illegal_keylen", 1'b0, 1'b0, 1'b1, 4'd0);
      repeat (3) tick();
      st_check("keylen_err_sticky", 1'b0, 1'b0, 1'b1, 4'd0);

      tick();
      expect_ready("a1_ready_lat", 8'd41, 4'd10);
      start(2'b00, KEY_A1);
      st_check("a1_busy_err_clear", 1'b0, 1'b1, 1'b0, 4'd0);
      wait_ready();
      rd_check("a1_rk0", 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      rd_check("a1_rk1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
      rd_check("a1_rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      rd_check("a1_rk11_oob", 4'd11, 128'h0);

      expect_ready("a2_ready_lat", 8'd47, 4'd12);
      start(2'b01, KEY_A2);
      st_check("a2_restart", 1'b0, 1'b1, 1'b0, 4'd10);
      wait_ready();
      rd_check("a2_rk0", 4'd0, 128'h8e73b0f7da0e6452c810f32b809079e5);
      rd_check("a2_rk1", 4'd1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
      rd_check("a2_rk12", 4'd12, 128'he98ba06f448c773c8ecc720401002202);
      rd_check("a2_rk13_oob", 4'd13, 128'h0);

      // Reset lands mid-expansion: no ready may follow
      start(2'b10, KEY_A3);
      repeat (19) tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      st_check("mid_run_reset", 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      rd_check("reset_store_rk0", 4'd0, 128'h0);

      expect_ready("a1b_ready_lat", 8'd41, 4'd10);
      start(2'b00, KEY_A1);
      wait_ready();
      rd_check("a1b_rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      expect_ready("a3_ready_lat", 8'd53, 4'd14);
      start(2'b10, KEY_A3);
      st_check("a3_b2b_ready_low", 1'b0, 1'b1, 1'b0, 4'd10);
      repeat (51) tick();
      st_check("a3_busy_last", 1'b0, 1'b1, 1'b0, 4'd10);
      wait_ready();
      rd_check("a3_rk1", 4'd1, 128'h1f352c073b6108d72d9810a30914dff4);
      rd_check("a3_rk2", 4'd2, 128'h9ba354118e6925afa51a8b5f2067fcde);
      rd_check("a3_rk3", 4'd3, 128'ha8b09c1a93d194cdbe49846eb75d5b9a);
      rd_check("a3_rk14", 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
      rd_check("a3_rk15_oob", 4'd15, 128'h0);

      repeat (4) tick();
      while (q_st_exp.size() > 0) begin
         n_checks++;
         $display("FAIL %s: got no sample expected %h", q_st_name.pop_front(), q_st_exp.pop_front());
      end
      while (q_rd_exp.size() > 0) begin
         n_checks++;
         $display("FAIL %s: got no read expected %h", q_rd_name.pop_front(), q_rd_exp.pop_front());
      end
      while (q_lat_exp.size() > 0) begin
         n_checks++;
         $display("FAIL %s: got no ready expected %h", q_lat_name.pop_front(), q_lat_exp.pop_front());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
